// File: rtl/cdu_sched_pkg.sv
// Shared types, default sizes and saturating arithmetic for the CDU pulse scheduler.
package cdu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int NCH_DEF     = 5;
    localparam int PEND_W_DEF  = 4;
    localparam int PULSE_W_DEF = 8;
    localparam int GAP_W_DEF   = 4;

    // Clamp a + d into the signed range of a w-bit two's complement value.
    function automatic int sat_add(input int a, input int d, input int w);
        int lo;
        int hi;
        int s;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        s  = a + d;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

    // True when a + d falls outside the w-bit signed range, i.e. the request is dropped.
    function automatic logic sat_drop(input int a, input int d, input int w);
        int lo;
        int hi;
        int s;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        s  = a + d;
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/cdu_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_i + 1, with wrap.
module cdu_rr_pick #(
    parameter int NCH   = 5,
    parameter int IDX_W = 3
) (
    input  logic [NCH-1:0]   req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NCH-1:0]   gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic found;

    // Outer loop walks priority order; inner loop keeps every index a loop constant.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && req_i[i] && (((int'(last_i) + k) % NCH) == i)) begin
                    found       = 1'b1;
                    gnt_oh_o[i] = 1'b1;
                    gnt_idx_o   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cdu_pulse_scheduler.sv
// Shares one AGC increment pulse path between the CDU channels: per-channel signed pending counts, round-robin grant per slot.
// Optional macro CDU_SCHED_OVF_EN builds sticky per-channel saturation flags on OVF; otherwise OVF is tied low.
module cdu_pulse_scheduler
    import cdu_sched_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int PEND_W  = PEND_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int GAP_W   = GAP_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           SLOT,
    input  logic           INH,
    input  logic [NCH-1:0] UP_REQ,
    input  logic [NCH-1:0] DN_REQ,
    input  logic [NCH-1:0] CDUZ,
    output logic [NCH-1:0] PLS_P,
    output logic [NCH-1:0] PLS_M,
    output logic           BUSY,
    output logic [NCH-1:0] PEND_NZ,
    output logic [NCH-1:0] OVF
);

    localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    sched_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [NCH-1:0]   pls_p_q, pls_p_d;
    logic [NCH-1:0]   pls_m_q, pls_m_d;
    logic             busy_q, busy_d;
    logic [NCH-1:0]   nz_q, nz_d;

    logic signed [PEND_W-1:0] pend_q [NCH];
    logic signed [PEND_W-1:0] pend_d [NCH];
    int                       step   [NCH];

    logic [NCH-1:0]   gnt_oh;
    logic [IDX_W-1:0] gnt_idx;
    logic [NCH-1:0]   pos;
    logic             dir_p;
    logic             grant;

    cdu_rr_pick #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (nz_q),
        .last_i    (last_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        pos = '0;
        for (int i = 0; i < NCH; i++) begin
            pos[i] = ~pend_q[i][PEND_W-1];
        end
        dir_p = |(gnt_oh & pos);
    end

    // Granted channels only ever have a nonzero count, so the sign step is always +/-1.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            step[i] = int'(UP_REQ[i]) - int'(DN_REQ[i]);
            if (grant && gnt_oh[i]) begin
                step[i] = step[i] + (pend_q[i][PEND_W-1] ? 1 : -1);
            end
        end
    end

    always_comb begin
        int sat_val;
        sat_val = 0;
        for (int i = 0; i < NCH; i++) begin
            sat_val   = sat_add(int'(pend_q[i]), step[i], PEND_W);
            pend_d[i] = CDUZ[i] ? '0 : PEND_W'(sat_val);
            nz_d[i]   = (pend_d[i] != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pls_p_d = '0;
        pls_m_d = '0;
        busy_d  = 1'b0;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SLOT && !INH && (|nz_q)) begin
                    grant   = 1'b1;
                    state_d = PULSE;
                    cnt_d   = CNT_W'(PULSE_W - 1);
                    last_d  = gnt_idx;
                    busy_d  = 1'b1;
                    if (dir_p) begin
                        pls_p_d = gnt_oh;
                    end else begin
                        pls_m_d = gnt_oh;
                    end
                end
            end
            PULSE: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_W - 1);
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    pls_p_d = pls_p_q;
                    pls_m_d = pls_m_q;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IDX_W'(NCH - 1);
            pls_p_q <= '0;
            pls_m_q <= '0;
            busy_q  <= 1'b0;
            nz_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pls_p_q <= pls_p_d;
            pls_m_q <= pls_m_d;
            busy_q  <= busy_d;
            nz_q    <= nz_d;
            for (int i = 0; i < NCH; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign PLS_P   = pls_p_q;
    assign PLS_M   = pls_m_q;
    assign BUSY    = busy_q;
    assign PEND_NZ = nz_q;

`ifdef CDU_SCHED_OVF_EN
    logic [NCH-1:0] ovf_q, ovf_d;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ovf_d[i] = CDUZ[i] ? 1'b0
                     : (ovf_q[i] | sat_drop(int'(pend_q[i]), step[i], PEND_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = '0;
`endif

endmodule
